// File: rtl/i_type_issue_if.sv
// Instruction handshake bundle between the fetch side and the I-type issue sequencer.
// The master offers instructions; the slave signals when it can take one.
interface i_type_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;

   modport master (output in_valid, output in_instr, input in_ready);
   modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/i_type_issue.sv
// Multi-cycle sequencer feeding the I-type ALU executor: accept, read rs1, execute, write back.
// Illegal OP-IMM encodings take a one-cycle ERR detour that raises the illegal pulse.
module i_type_issue #(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   i_type_issue_if.slave      in_bus,
   output logic [4:0]         rf_raddr,
   input  logic [31:0]        rf_rdata,
   output logic [31:0]        ex_idata,
   output logic [31:0]        ex_rv1,
   output logic [31:0]        ex_imm,
   input  logic [31:0]        ex_regdata,
   output logic               rf_we,
   output logic [4:0]         rf_waddr,
   output logic [31:0]        rf_wdata,
   output logic               illegal,
   output logic [CNT_W-1:0]   retired_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      RDREG,
      EXEC,
      WB,
      ERR
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [31:0]        instr_q;
   logic [31:0]        result_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ready;
   logic               take;
   logic [4:0]         rs1;
   logic [4:0]         rd;

   // Shift encodings constrain funct7; every other funct3 accepts any immediate.
   function automatic logic is_legal(input logic [6:0] funct7,
                                     input logic [2:0] funct3,
                                     input logic [6:0] opcode);
      logic ok;
      ok = (opcode == 7'b0010011);
      if (funct3 == 3'b001)
         ok = ok && (funct7 == 7'b0000000);
      else if (funct3 == 3'b101)
         ok = ok && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
      return ok;
   endfunction

   assign rs1 = instr_q[19:15];
   assign rd  = instr_q[11:7];

   always_comb begin
      next_state = state;
      ready      = (state == IDLE) || (state == WB);
      take       = in_bus.in_valid && ready;
      case (state)
         IDLE, WB: begin
            if (take)
               next_state = is_legal(in_bus.in_instr[31:25], in_bus.in_instr[14:12],
                                     in_bus.in_instr[6:0]) ? RDREG : ERR;
            else
               next_state = IDLE;
         end
         RDREG:   next_state = EXEC;
         EXEC:    next_state = WB;
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         instr_q  <= '0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         state <= next_state;
         if (take)
            instr_q <= in_bus.in_instr;
         if (state == EXEC)
            result_q <= ex_regdata;
         if (state == WB)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Outputs decode straight from state so reset silences rf_we and illegal at once.
   always_comb begin
      in_bus.in_ready = ready;
      rf_raddr        = (state == RDREG) ? rs1 : 5'd0;
      ex_idata        = instr_q;
      ex_imm          = {{20{instr_q[31]}}, instr_q[31:20]};
      ex_rv1          = ((state == EXEC) && (rs1 != 5'd0)) ? rf_rdata : 32'd0;
      rf_we           = (state == WB) && (rd != 5'd0);
      rf_waddr        = rd;
      rf_wdata        = result_q;
      illegal         = (state == ERR);
      retired_cnt     = cnt_q;
   end

endmodule

// File: tb/tb_i_type_issue.sv
// Self-checking bench for i_type_issue: register-file and executor harness plus an
// architectural model (golden register array, retire count) driven by directed and random instructions.
module tb_i_type_issue;
   localparam int CNT_W = 32;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [4:0]         rf_raddr;
   logic [31:0]        rf_rdata;
   logic [31:0]        ex_idata;
   logic [31:0]        ex_rv1;
   logic [31:0]        ex_imm;
   logic [31:0]        ex_regdata;
   logic               rf_we;
   logic [4:0]         rf_waddr;
   logic [31:0]        rf_wdata;
   logic               illegal;
   logic [CNT_W-1:0]   retired_cnt;

   i_type_issue_if bus();

   i_type_issue #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_bus      (bus),
      .rf_raddr    (rf_raddr),
      .rf_rdata    (rf_rdata),
      .ex_idata    (ex_idata),
      .ex_rv1      (ex_rv1),
      .ex_imm      (ex_imm),
      .ex_regdata  (ex_regdata),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .illegal     (illegal),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   int               checks = 0;
   int               failures = 0;
   logic [31:0]      gold [32];
   logic [31:0]      rf [32];
   bit               rf_loaded = 1'b0;
   logic [CNT_W-1:0] exp_cnt = '0;

   // x0 in the harness holds garbage so a missing rs1=0 override shows up.
   function automatic logic [31:0] init_val(input int i);
      if (i == 0) return 32'hDEAD_BEEF;
      return (32'h1357_9BDF * 32'(i)) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] imm);
      case (f3)
         3'd0: return a + imm;
         3'd2: return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
         3'd3: return (a < imm) ? 32'd1 : 32'd0;
         3'd4: return a ^ imm;
         3'd6: return a | imm;
         3'd7: return a & imm;
         3'd1: return a << imm[4:0];
         default: return alt ? 32'($signed(a) >>> imm[4:0]) : (a >> imm[4:0]);
      endcase
   endfunction

   function automatic bit ref_legal(input logic [31:0] w);
      if (w[6:0] != 7'h13) return 1'b0;
      if (w[14:12] == 3'd1) return w[31:25] == 7'h00;
      if (w[14:12] == 3'd5) return (w[31:25] == 7'h00) || (w[31:25] == 7'h20);
      return 1'b1;
   endfunction

   // Register file with a registered read port, and a combinational executor.
   always @(posedge clk) begin
      if (!rf_loaded) begin
         for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
         rf_loaded <= 1'b1;
      end else if (rf_we) begin
         rf[rf_waddr] <= rf_wdata;
      end
      rf_rdata <= rf[rf_raddr];
   end

   assign ex_regdata = ref_op(ex_idata[14:12], ex_idata[30], ex_rv1, ex_imm);

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Offers one instruction (from IDLE or WB) and follows it to its WB cycle or ERR exit.
   task automatic applyStimulus(input logic [31:0] instr);
      logic [4:0]  rs1;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] imm;
      logic [31:0] res;
      bit          ok;
      int          waited;
      rs1 = instr[19:15];
      rd  = instr[11:7];
      imm = {{20{instr[31]}}, instr[31:20]};
      ok  = ref_legal(instr);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      waited = 0;
      while (!bus.in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("in_ready_accept", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_instr = $urandom;
      @(negedge clk);
      checkOutput("in_ready_c1", 32'(bus.in_ready), 32'd0);
      checkOutput("rf_we_c1", 32'(rf_we), 32'd0);
      checkOutput("retired_c1", retired_cnt, exp_cnt);
      checkOutput("ex_idata", ex_idata, instr);
      if (!ok) begin
         checkOutput("illegal_c1", 32'(illegal), 32'd1);
         @(negedge clk);
         checkOutput("illegal_c2", 32'(illegal), 32'd0);
         checkOutput("in_ready_c2", 32'(bus.in_ready), 32'd1);
         checkOutput("rf_we_c2_err", 32'(rf_we), 32'd0);
         checkOutput("retired_c2_err", retired_cnt, exp_cnt);
         return;
      end
      checkOutput("illegal_c1_legal", 32'(illegal), 32'd0);
      checkOutput("rf_raddr", 32'(rf_raddr), 32'(rs1));
      @(negedge clk);
      a = gold[rs1];
      res = ref_op(instr[14:12], instr[30], a, imm);
      checkOutput("ex_rv1", ex_rv1, a);
      checkOutput("ex_imm", ex_imm, imm);
      checkOutput("rf_we_c2", 32'(rf_we), 32'd0);
      @(negedge clk);
      checkOutput("rf_we_wb", 32'(rf_we), 32'(rd != 5'd0));
      checkOutput("rf_waddr", 32'(rf_waddr), 32'(rd));
      checkOutput("rf_wdata", rf_wdata, res);
      checkOutput("in_ready_wb", 32'(bus.in_ready), 32'd1);
      if (rd != 5'd0) gold[rd] = res;
      exp_cnt = exp_cnt + CNT_W'(1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] w;
      logic [6:0]  f7;
      int          kind;
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      for (int i = 0; i < 32; i++) gold[i] = (i == 0) ? 32'd0 : init_val(i);

      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_retired", retired_cnt, 32'd0);
      checkOutput("rst_ex_idata", ex_idata, 32'd0);
      checkOutput("rst_ex_imm", ex_imm, 32'd0);
      checkOutput("rst_ex_rv1", ex_rv1, 32'd0);
      checkOutput("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      checkOutput("rst_rf_wdata", rf_wdata, 32'd0);
      rst_n = 1'b1;
      $display("[TB] reset released");

      applyStimulus(32'hFFF0_0293);
      applyStimulus(32'h0050_0093);
      applyStimulus(32'h0030_8113);
      applyStimulus(32'h0070_8013);
      @(negedge clk);
      checkOutput("rf_x1", rf[1], 32'd5);
      checkOutput("rf_x2", rf[2], 32'd8);
      checkOutput("rf_x5", rf[5], 32'hFFFF_FFFF);

      applyStimulus(32'h0000_0033);
      applyStimulus(32'h4000_9093);
      applyStimulus(32'h0200_D093);

      applyStimulus(32'h0010_0093);
      applyStimulus(32'h01F0_9093);
      applyStimulus(32'h4040_D193);
      checkOutput("srai_bit30", 32'(ex_idata[30]), 32'd1);
      checkOutput("srai_shamt", 32'(ex_imm[4:0]), 32'd4);
      @(negedge clk);
      checkOutput("srai_rf_x3", rf[3], 32'hF800_0000);

      // Reset while ERR is active must drop illegal without waiting for a clock.
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h0000_0033;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("err_illegal", 32'(illegal), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_illegal", 32'(illegal), 32'd0);
      exp_cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(32'h0050_8093);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h0050_8093;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_rst_ex_rv1", ex_rv1, gold[1]);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rf_we", 32'(rf_we), 32'd0);
      checkOutput("async_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("async_retired", retired_cnt, 32'd0);
      exp_cnt = '0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("rst_hold_rf_we", 32'(rf_we), 32'd0);
      end
      rst_n = 1'b1;
      checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      applyStimulus(32'h0050_8093);
      $display("[TB] directed steps complete");

      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 9));
         w = $urandom;
         w[6:0] = 7'h13;
         if (kind == 0) begin
            w[6:0] = 7'($urandom_range(0, 127));
            if (w[6:0] == 7'h13) w[6:0] = 7'h33;
         end else if (kind == 1) begin
            w[14:12] = 3'd1;
            w[31:25] = 7'($urandom_range(1, 127));
         end else if (kind == 2) begin
            w[14:12] = 3'd5;
            f7 = 7'($urandom_range(1, 126));
            if (f7 >= 7'h20) f7 = f7 + 7'd1;
            w[31:25] = f7;
         end else if (w[14:12] == 3'd1) begin
            w[31:25] = 7'h00;
         end else if (w[14:12] == 3'd5) begin
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         end
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         applyStimulus(w);
      end

      @(negedge clk);
      checkOutput("final_retired", retired_cnt, exp_cnt);
      for (int i = 1; i < 32; i++) checkOutput("final_rf", rf[i], gold[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
